// File: rtl/fe_pkg.sv
// Shared Curve25519 field definitions: element width, the prime, the
// default inversion exponent, an MSB-index helper and the state encoding
// of the exponentiation controller.
package fe_pkg;

    localparam int FE_WIDTH = 255;

    // p = 2^255 - 19
    localparam logic [FE_WIDTH-1:0] FE_P =
        255'h7fffffffffffffff_ffffffffffffffff_ffffffffffffffff_ffffffffffffffed;

    // p - 2: Fermat exponent, x^(p-2) = x^-1 mod p
    localparam logic [FE_WIDTH-1:0] FE_P_MINUS_2 =
        255'h7fffffffffffffff_ffffffffffffffff_ffffffffffffffff_ffffffffffffffeb;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQR_REQ,
        ST_SQR_WAIT,
        ST_MUL_REQ,
        ST_MUL_WAIT,
        ST_DONE
    } pow_state_t;

    // Index of the most significant set bit; 0 when exp is 0 or 1.
    function automatic int fe_msb_index(input logic [FE_WIDTH-1:0] exp);
        int msb;
        msb = 0;
        for (int i = 0; i < FE_WIDTH; i++) begin
            if (exp[i]) msb = i;
        end
        return msb;
    endfunction

endpackage

// File: rtl/ffm_pow.sv
// Left-to-right square-and-multiply exponentiation x^EXP mod p for the
// Curve25519 field. All arithmetic is delegated to an external ffm
// multiplier through the mul_* handshake; this block only sequences it.
// Optional feature macro: FFM_POW_OPCNT_EN adds the op_count output
// (number of multiplier operations issued by the last exponentiation).
module ffm_pow
    import fe_pkg::*;
#(
    parameter int               WIDTH = FE_WIDTH,
    parameter logic [WIDTH-1:0] EXP   = WIDTH'(FE_P_MINUS_2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             busy,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_result,
    input  logic             mul_valid
`ifdef FFM_POW_OPCNT_EN
    ,
    output logic [15:0]      op_count
`endif
);

    // Position of the leading exponent bit; it is consumed by acc <= x.
    localparam logic [7:0] TOP      = 8'(fe_msb_index(FE_WIDTH'(EXP)));
    localparam logic       EXP_ZERO = (EXP == '0);

    pow_state_t       state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] x_reg, x_next;
    logic [7:0]       idx_reg, idx_next;
    logic [WIDTH-1:0] result_reg;
    logic             valid_reg;

    // State and datapath registers; result/valid are published the cycle
    // after DONE so both appear together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            x_reg      <= '0;
            idx_reg    <= '0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            x_reg     <= x_next;
            idx_reg   <= idx_next;
            valid_reg <= (state_reg == ST_DONE);
            if (state_reg == ST_DONE) begin
                result_reg <= acc_reg;
            end
        end
    end

    // Next-state logic and multiplier request decode. Operands are driven
    // from acc/x_reg through the whole wait state, and acc only changes on
    // the mul_valid edge, so they stay stable for the multiplier.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        x_next     = x_reg;
        idx_next   = idx_reg;
        mul_start  = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    x_next   = x;
                    acc_next = x;
                    if (EXP_ZERO) begin
                        acc_next   = WIDTH'(1);
                        state_next = ST_DONE;
                    end else if (TOP == 8'd0) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = TOP - 8'd1;
                        state_next = ST_SQR_REQ;
                    end
                end
            end
            ST_SQR_REQ: begin
                mul_start  = 1'b1;
                mul_a      = acc_reg;
                mul_b      = acc_reg;
                state_next = ST_SQR_WAIT;
            end
            ST_SQR_WAIT: begin
                mul_a = acc_reg;
                mul_b = acc_reg;
                if (mul_valid) begin
                    acc_next = mul_result;
                    if (EXP[idx_reg]) begin
                        state_next = ST_MUL_REQ;
                    end else if (idx_reg == 8'd0) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_reg - 8'd1;
                        state_next = ST_SQR_REQ;
                    end
                end
            end
            ST_MUL_REQ: begin
                mul_start  = 1'b1;
                mul_a      = acc_reg;
                mul_b      = x_reg;
                state_next = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                mul_a = acc_reg;
                mul_b = x_reg;
                if (mul_valid) begin
                    acc_next = mul_result;
                    if (idx_reg == 8'd0) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_reg - 8'd1;
                        state_next = ST_SQR_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign result = result_reg;
    assign valid  = valid_reg;
    // Busy covers the whole run including the cycle valid is shown.
    assign busy   = (state_reg != ST_IDLE) || valid_reg;

`ifdef FFM_POW_OPCNT_EN
    logic [15:0] op_count_reg;

    // Operation counter: restarts on accept, stops moving once idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count_reg <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            op_count_reg <= '0;
        end else if (mul_start) begin
            op_count_reg <= op_count_reg + 16'd1;
        end
    end

    assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_ffm_pow.sv
// Bench for ffm_pow: instance A uses the default inversion exponent p-2,
// instance B uses EXP = 5. Each has a behavioural multiplier with Lm = 3.
module tb_ffm_pow;
    import fe_pkg::*;

    localparam int LM = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Instance A signals
    logic         start_a = 1'b0;
    logic [254:0] x_a = '0;
    logic [254:0] result_a, mul_a_a, mul_b_a;
    logic         valid_a, busy_a, mul_start_a;
    logic [254:0] mres_a = '0;
    logic         mval_a = 1'b0;
    int           mcnt_a = 0;
    int           ops_a = 0;

    // Instance B signals
    logic         start_b = 1'b0;
    logic [254:0] x_b = '0;
    logic [254:0] result_b, mul_a_b, mul_b_b;
    logic         valid_b, busy_b, mul_start_b;
    logic [254:0] mres_b = '0;
    logic         mval_b = 1'b0;
    int           mcnt_b = 0;
    int           ops_b = 0;

`ifdef FFM_POW_OPCNT_EN
    logic [15:0]  op_count_a, op_count_b;
`endif

    int checks = 0;
    int failures = 0;

    ffm_pow u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .x          (x_a),
        .result     (result_a),
        .valid      (valid_a),
        .busy       (busy_a),
        .mul_start  (mul_start_a),
        .mul_a      (mul_a_a),
        .mul_b      (mul_b_a),
        .mul_result (mres_a),
        .mul_valid  (mval_a)
`ifdef FFM_POW_OPCNT_EN
        ,
        .op_count   (op_count_a)
`endif
    );

    ffm_pow #(.EXP(255'd5)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .x          (x_b),
        .result     (result_b),
        .valid      (valid_b),
        .busy       (busy_b),
        .mul_start  (mul_start_b),
        .mul_a      (mul_a_b),
        .mul_b      (mul_b_b),
        .mul_result (mres_b),
        .mul_valid  (mval_b)
`ifdef FFM_POW_OPCNT_EN
        ,
        .op_count   (op_count_b)
`endif
    );

    function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
        logic [509:0] prod;
        logic [509:0] modv;
        prod = {255'd0, a} * {255'd0, b};
        modv = prod % {255'd0, FE_P};
        return modv[254:0];
    endfunction

    // Multiplier models: not reset, so a product in flight survives a DUT reset.
    always @(posedge clk) begin
        mval_a <= 1'b0;
        if (mul_start_a) begin
            mres_a <= mulmod(mul_a_a, mul_b_a);
            mcnt_a <= LM - 1;
            ops_a  <= ops_a + 1;
        end else if (mcnt_a > 0) begin
            if (mcnt_a == 1) mval_a <= 1'b1;
            mcnt_a <= mcnt_a - 1;
        end
    end

    always @(posedge clk) begin
        mval_b <= 1'b0;
        if (mul_start_b) begin
            mres_b <= mulmod(mul_a_b, mul_b_b);
            mcnt_b <= LM - 1;
            ops_b  <= ops_b + 1;
        end else if (mcnt_b > 0) begin
            if (mcnt_b == 1) mval_b <= 1'b1;
            mcnt_b <= mcnt_b - 1;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One exponentiation on instance sel (0=A, 1=B). With poke set, a second
    // start with a different x is pulsed while busy.
    task automatic run(input int sel, input logic [254:0] xv, input bit poke,
                       output logic [254:0] res, output int cyc, output int ops);
        int  ops0;
        bit  found;
        logic v;
        ops0  = (sel == 1) ? ops_b : ops_a;
        found = 1'b0;
        cyc   = 0;
        @(negedge clk);
        if (sel == 1) begin start_b = 1'b1; x_b = xv; end
        else          begin start_a = 1'b1; x_a = xv; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check("busy_after_accept", (sel == 1) ? busy_b : busy_a, 1'b1);
        for (int n = 1; n <= 5000 && !found; n++) begin
            if (n > 1) @(negedge clk);
            if (poke && n == 5) begin start_b = 1'b1; x_b = 255'd7; end
            if (poke && n == 6) start_b = 1'b0;
            v = (sel == 1) ? valid_b : valid_a;
            if (v) begin
                found = 1'b1;
                cyc   = n;
            end
        end
        check("valid_seen", found, 1'b1);
        res = (sel == 1) ? result_b : result_a;
        ops = ((sel == 1) ? ops_b : ops_a) - ops0;
        @(negedge clk);
        check("valid_one_cycle", (sel == 1) ? valid_b : valid_a, 1'b0);
        $display("run inst=%0d x=%h result=%h cycles=%0d ops=%0d", sel, xv, res, cyc, ops);
    endtask

    initial begin
        logic [254:0] res;
        int cyc, ops, ops0, extra;
        bit found, saw_busy, saw_req;

        repeat (3) @(negedge clk);
        check("rst_result", result_a, '0);
        check("rst_valid", valid_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_mul_start", mul_start_a, 1'b0);
        check("rst_mul_a", mul_a_a, '0);
        check("rst_mul_b", mul_b_a, '0);
`ifdef FFM_POW_OPCNT_EN
        check("rst_op_count", op_count_a, '0);
`endif
        rst = 1'b1;

        // x = 1: inverse is 1; 254 squarings + 252 multiplies
        run(0, 255'd1, 1'b0, res, cyc, ops);
        check("inv1_result", res, 255'd1);
        check("inv1_ops", ops, 506);
        check("inv1_latency", cyc, 2 + 506 * (LM + 1));
`ifdef FFM_POW_OPCNT_EN
        check("inv1_op_count", op_count_a, 16'd506);
`endif

        // x = 2: inverse is (p+1)/2
        run(0, 255'd2, 1'b0, res, cyc, ops);
        check("inv2_result", res,
              255'h3fffffffffffffff_ffffffffffffffff_ffffffffffffffff_fffffffffffffff7);

        // x = 33: 33 * inverse must be 1
        run(0, 255'd33, 1'b0, res, cyc, ops);
        check("inv33_product", mulmod(255'd33, res), 255'd1);

        // Reset in the middle of operation 100
        ops0 = ops_a;
        @(negedge clk);
        start_a = 1'b1;
        x_a     = 255'd5;
        @(negedge clk);
        start_a = 1'b0;
        found   = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            if (ops_a - ops0 >= 100) found = 1'b1;
            else @(negedge clk);
        end
        check("op100_reached", found, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_result", result_a, '0);
        check("mid_rst_valid", valid_a, 1'b0);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_mul_start", mul_start_a, 1'b0);
        check("mid_rst_mul_a", mul_a_a, '0);
        check("mid_rst_mul_b", mul_b_a, '0);
        @(negedge clk);
        rst = 1'b1;
        // The model's stale product lands now; the DUT must stay idle.
        saw_busy = 1'b0;
        saw_req  = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (busy_a) saw_busy = 1'b1;
            if (mul_start_a) saw_req = 1'b1;
        end
        check("stale_busy", saw_busy, 1'b0);
        check("stale_mul_start", saw_req, 1'b0);
        check("stale_result", result_a, '0);

        // Fresh run after reset
        run(0, 255'd1, 1'b0, res, cyc, ops);
        check("post_rst_result", res, 255'd1);
        check("post_rst_ops", ops, 506);

        // x = 0: result 0, exactly one valid pulse
        run(0, 255'd0, 1'b0, res, cyc, ops);
        check("inv0_result", res, '0);
        extra = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (valid_a) extra++;
        end
        check("inv0_extra_valid", extra, 0);

        // EXP = 5, x = 3: 243 in 3 ops, 14 cycles; second start ignored
        run(1, 255'd3, 1'b1, res, cyc, ops);
        check("exp5_result", res, 255'd243);
        check("exp5_ops", ops, 3);
        check("exp5_latency", cyc, 14);
`ifdef FFM_POW_OPCNT_EN
        check("exp5_op_count", op_count_b, 16'd3);
`endif
        repeat (10) @(negedge clk);
        check("exp5_no_rerun", ops_b - ops0 + ops0 - ops_b + (busy_b ? 1 : 0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
